mips_div: RTL

Multi-cycle 32-bit integer divider for the execute stage; it produces the {HI, LO} pair written by DIV/DIVU into the HI/LO register file. Radix-2 restoring algorithm, one quotient bit per cycle, 32 iterations; execute stalls on `busy_o` until `ready_o`. It sits directly upstream of the HI/LO registers: execute forwards `result_o[63:32]` as HI and `result_o[31:0]` as LO with the HI/LO write enable on the `ready_o` cycle.

---
 rtl/mips_div.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mips_div.sv
// rtl/mips_div.sv - radix-2 restoring 32-bit divider producing {HI, LO} for DIV/DIVU
module mips_div #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    input  logic               annul_i,
    output logic               busy_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ZERO,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_q_neg;
    logic               r_r_neg;
    logic [2*WIDTH-1:0] r_result;

    logic               w_accept;
    logic               w_last;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nx;
    logic [WIDTH-1:0]   w_quo_nx;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    assign w_accept = (r_state == S_IDLE) && start_i && !annul_i;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // Signed operands are divided as magnitudes; signs are reapplied at the end.
    assign w_a_neg  = signed_i & dividend_i[WIDTH-1];
    assign w_b_neg  = signed_i & divisor_i[WIDTH-1];
    assign w_a_abs  = w_a_neg ? -dividend_i : dividend_i;
    assign w_b_abs  = w_b_neg ? -divisor_i : divisor_i;

    assign w_shift  = {r_rem, r_quo[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, r_dvs};
    assign w_ge     = !w_diff[WIDTH];
    assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};
    assign w_q_fix  = r_q_neg ? -w_quo_nx : w_quo_nx;
    assign w_r_fix  = r_r_neg ? -w_rem_nx : w_rem_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (divisor_i == '0) ? S_ZERO : S_RUN;
                end
            end
            S_ZERO:  w_next = annul_i ? S_IDLE : S_DONE;
            S_RUN: begin
                if (annul_i) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= w_a_abs;
            r_dvs    <= w_b_abs;
            r_q_neg  <= w_a_neg ^ w_b_neg;
            r_r_neg  <= w_a_neg;
        end else if (r_state == S_RUN && !annul_i) begin
            r_cnt <= r_cnt + 1'b1;
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            if (w_last) begin
                r_result <= {w_r_fix, w_q_fix};
            end
        end else if (r_state == S_ZERO && !annul_i) begin
            // Division by zero is architecturally undefined; we commit all zeros.
            r_result <= '0;
        end
    end

    assign busy_o   = (r_state == S_ZERO) || (r_state == S_RUN);
    assign ready_o  = (r_state == S_DONE);
    assign result_o = r_result;

endmodule
